// File: rtl/osc_phase_accum.sv
// Time-multiplexed phase accumulator bank: one PH_WIDTH-bit phase per {voice, osc} slot,
// advanced once per frame by the aligned pitch increment, with key-on reset and osc-0 hard sync.
module osc_phase_accum #(
   parameter int VOICES    = 8,
   parameter int V_OSC     = 4,
   parameter int V_WIDTH   = 3,
   parameter int O_WIDTH   = 2,
   parameter int OE_WIDTH  = 1,
   parameter int E_WIDTH   = O_WIDTH + OE_WIDTH,
   parameter int PITCH_DLY = 3,
   parameter int PH_WIDTH  = 32
) (
   input  logic                        sCLK_XVXOSC,
   input  logic                        reset_reg_N,
   input  logic [V_WIDTH+E_WIDTH-1:0]  xxxx,
   input  logic [23:0]                 osc_pitch_val,
   input  logic                        note_on,
   input  logic [V_WIDTH-1:0]          cur_key_adr,
   input  logic [V_OSC-1:0]            sync_mask,
   output logic [PH_WIDTH-1:0]         phase_out,
   output logic [V_WIDTH+O_WIDTH-1:0]  phase_slot,
   output logic                        phase_valid,
   output logic                        osc_wrap
);

   localparam int S_WIDTH = V_WIDTH + E_WIDTH;
   localparam int I_WIDTH = V_WIDTH + O_WIDTH;
   localparam int N_SLOT  = VOICES * V_OSC;

   logic [S_WIDTH-1:0]  dly_q [PITCH_DLY];
   logic [S_WIDTH-1:0]  dly_d [PITCH_DLY];
   logic [PITCH_DLY-1:0] vld_q, vld_d;
   logic [PH_WIDTH-1:0] phase_q [N_SLOT];
   logic [PH_WIDTH-1:0] phase_d [N_SLOT];
   logic [N_SLOT-1:0]   pend_q, pend_d;
   logic                note_q, note_d;
   logic [PH_WIDTH-1:0] phase_out_q, phase_out_d;
   logic [I_WIDTH-1:0]  phase_slot_q, phase_slot_d;
   logic                phase_valid_q, phase_valid_d;
   logic                osc_wrap_q, osc_wrap_d;

   logic [S_WIDTH-1:0]  slot_al;
   logic [V_WIDTH-1:0]  vd;
   logic [O_WIDTH-1:0]  od;
   logic [OE_WIDTH-1:0] sub;
   logic [I_WIDTH-1:0]  idx;
   logic [PH_WIDTH-1:0] inc;
   logic [PH_WIDTH:0]   sum;
   logic [N_SLOT-1:0]   set_vec;

   always_comb begin
      dly_d[0] = xxxx;
      for (int i = 1; i < PITCH_DLY; i++) dly_d[i] = dly_q[i-1];
      // The validity shadow keeps the cleared delay line from producing updates after reset.
      vld_d[0] = 1'b1;
      for (int i = 1; i < PITCH_DLY; i++) vld_d[i] = vld_q[i-1];
      note_d = note_on;

      phase_d       = phase_q;
      pend_d        = pend_q;
      phase_out_d   = phase_out_q;
      phase_slot_d  = phase_slot_q;
      phase_valid_d = 1'b0;
      osc_wrap_d    = 1'b0;
      set_vec       = '0;
      sum           = '0;

      slot_al = dly_q[PITCH_DLY-1];
      vd      = slot_al[S_WIDTH-1:E_WIDTH];
      od      = slot_al[E_WIDTH-1:OE_WIDTH];
      sub     = slot_al[OE_WIDTH-1:0];
      idx     = {vd, od};
      inc     = PH_WIDTH'(osc_pitch_val);

      if (vld_q[PITCH_DLY-1] && sub == '0) begin
         if (pend_q[idx]) begin
            sum         = {1'b0, inc};
            pend_d[idx] = 1'b0;
         end else begin
            sum = {1'b0, phase_q[idx]} + {1'b0, inc};
         end
         phase_d[idx]  = sum[PH_WIDTH-1:0];
         phase_out_d   = sum[PH_WIDTH-1:0];
         phase_slot_d  = idx;
         phase_valid_d = 1'b1;
         osc_wrap_d    = sum[PH_WIDTH];
         if (od == '0 && sum[PH_WIDTH]) begin
            for (int i = 0; i < V_OSC; i++)
               if (i != 0 && sync_mask[i]) set_vec[{vd, O_WIDTH'(i)}] = 1'b1;
         end
      end

      if (note_on && !note_q) begin
         for (int o = 0; o < V_OSC; o++) set_vec[{cur_key_adr, O_WIDTH'(o)}] = 1'b1;
      end
      // Applied after the clear so a same-cycle set survives.
      pend_d = pend_d | set_vec;
   end

   always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         for (int i = 0; i < PITCH_DLY; i++) dly_q[i] <= '0;
         for (int i = 0; i < N_SLOT; i++) phase_q[i] <= '0;
         vld_q         <= '0;
         pend_q        <= '0;
         note_q        <= 1'b0;
         phase_out_q   <= '0;
         phase_slot_q  <= '0;
         phase_valid_q <= 1'b0;
         osc_wrap_q    <= 1'b0;
      end else begin
         dly_q         <= dly_d;
         phase_q       <= phase_d;
         vld_q         <= vld_d;
         pend_q        <= pend_d;
         note_q        <= note_d;
         phase_out_q   <= phase_out_d;
         phase_slot_q  <= phase_slot_d;
         phase_valid_q <= phase_valid_d;
         osc_wrap_q    <= osc_wrap_d;
      end
   end

   assign phase_out   = phase_out_q;
   assign phase_slot  = phase_slot_q;
   assign phase_valid = phase_valid_q;
   assign osc_wrap    = osc_wrap_q;

endmodule

// File: tb/tb_osc_phase_accum.sv
// Bench for osc_phase_accum: cycle-by-cycle comparison against a slot-level reference
// model, plus directed sequences for latency, wrap, hard sync, key-on and reset.
module tb_osc_phase_accum;

   logic        clk = 1'b0;
   logic        reset_reg_N;
   logic [5:0]  xxxx;
   logic [23:0] osc_pitch_val;
   logic        note_on;
   logic [2:0]  cur_key_adr;
   logic [3:0]  sync_mask;
   logic [31:0] phase_out;
   logic [4:0]  phase_slot;
   logic        phase_valid;
   logic        osc_wrap;

   always #5 clk = ~clk;

   osc_phase_accum dut (
      .sCLK_XVXOSC  (clk),
      .reset_reg_N  (reset_reg_N),
      .xxxx         (xxxx),
      .osc_pitch_val(osc_pitch_val),
      .note_on      (note_on),
      .cur_key_adr  (cur_key_adr),
      .sync_mask    (sync_mask),
      .phase_out    (phase_out),
      .phase_slot   (phase_slot),
      .phase_valid  (phase_valid),
      .osc_wrap     (osc_wrap)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: one phase and one pending flag per oscillator (voice*4 + osc).
   logic [31:0] m_phase [32];
   bit          m_pend  [32];
   bit          m_prev_note;
   logic [31:0] m_out;
   logic [4:0]  m_slot;
   bit          m_valid, m_wrap;
   logic [5:0]  hq [$];
   logic [23:0] inc_tbl [32];
   bit          rand_inc;

   typedef struct {
      string       name;
      int          slot;
      logic [31:0] exp_ph;
      logic        exp_wrap;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_phase[i] = '0;
         m_pend[i]  = 1'b0;
      end
      m_prev_note = 1'b0;
      m_out = '0; m_slot = '0; m_valid = 1'b0; m_wrap = 1'b0;
      hq.delete();
   endtask

   task automatic model_edge(input bit v, input logic [5:0] s);
      logic [32:0] sum;
      bit   [31:0] setv;
      int          id, voice, osc;
      setv = '0;
      if (v && s[0] == 1'b0) begin
         voice = int'(s[5:3]);
         osc   = int'(s[2:1]);
         id    = voice * 4 + osc;
         if (m_pend[id]) begin
            sum = 33'(osc_pitch_val);
            m_pend[id] = 1'b0;
         end else begin
            sum = 33'(m_phase[id]) + 33'(osc_pitch_val);
         end
         m_phase[id] = sum[31:0];
         m_out = sum[31:0]; m_slot = 5'(id); m_valid = 1'b1; m_wrap = sum[32];
         if (osc == 0 && sum[32])
            for (int i = 1; i < 4; i++) if (sync_mask[i]) setv[voice*4+i] = 1'b1;
      end else begin
         m_valid = 1'b0; m_wrap = 1'b0;
      end
      if (note_on && !m_prev_note)
         for (int o = 0; o < 4; o++) setv[int'(cur_key_adr)*4+o] = 1'b1;
      m_prev_note = note_on;
      for (int i = 0; i < 32; i++) if (setv[i]) m_pend[i] = 1'b1;
   endtask

   task automatic step();
      bit         v;
      logic [5:0] s;
      v = (hq.size() >= 3);
      s = v ? hq[$-2] : 6'd0;
      if (rand_inc)  osc_pitch_val = 24'($urandom);
      else if (v)    osc_pitch_val = inc_tbl[s[5:1]];
      else           osc_pitch_val = 24'($urandom);
      model_edge(v, s);
      @(posedge clk); #1;
      hq.push_back(xxxx);
      if (hq.size() > 3) void'(hq.pop_front());
      chk("model{out,slot,vld,wrap}", {25'b0, phase_out, phase_slot, phase_valid, osc_wrap},
          {25'b0, m_out, m_slot, m_valid, m_wrap});
      xxxx = xxxx + 6'd1;
   endtask

   task automatic wait_slot(input int slot, output logic [31:0] po, output logic pw);
      bit found = 1'b0;
      po = '0; pw = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         step();
         if (phase_valid && phase_slot == 5'(slot)) begin
            found = 1'b1; po = phase_out; pw = osc_wrap;
         end
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_slot_%0d: no strobe in 200 cycles, required one", slot);
      end
   endtask

   task automatic hit_reset();
      reset_reg_N = 1'b0;
      #1;
      chk("reset_outputs_async", {25'b0, phase_out, phase_slot, phase_valid, osc_wrap}, 64'd0);
      model_reset();
      @(posedge clk); #1;
      reset_reg_N = 1'b1;
      xxxx = '0;
   endtask

   task automatic first_strobe(input logic [31:0] exp_ph);
      int n = 0;
      do begin step(); n++; end while (!phase_valid && n < 20);
      chk("first_strobe_latency", 64'(n), 64'd4);
      chk("first_strobe_slot", 64'(phase_slot), 64'd0);
      chk("first_strobe_phase", 64'(phase_out), 64'(exp_ph));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      vec_t        wvec[6];
      logic [31:0] po;
      logic        pw;

      wvec[0] = '{"osc2_f256",   10, 32'h0000_1000, 1'b0};
      wvec[1] = '{"osc0_f257",    8, 32'h00FF_FEFF, 1'b1};
      wvec[2] = '{"osc1_f257",    9, 32'h00FF_FEFF, 1'b1};
      wvec[3] = '{"osc2_synced", 10, 32'h0000_0010, 1'b0};
      wvec[4] = '{"osc3_f257",   11, 32'h0000_2020, 1'b0};
      wvec[5] = '{"osc2_f258",   10, 32'h0000_0020, 1'b0};

      reset_reg_N = 1'b0; xxxx = '0; osc_pitch_val = '0; note_on = 1'b0;
      cur_key_adr = '0; sync_mask = '0; rand_inc = 1'b0;
      for (int i = 0; i < 32; i++) inc_tbl[i] = 24'h000100;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {25'b0, phase_out, phase_slot, phase_valid, osc_wrap}, 64'd0);
      reset_reg_N = 1'b1;

      // Basic accumulation, latency and strobe spacing.
      first_strobe(32'h100);
      step(); chk("strobe_gap_low", 64'(phase_valid), 64'd0);
      step(); chk("strobe_gap_high", 64'(phase_valid), 64'd1);
      for (int f = 2; f <= 4; f++) begin
         wait_slot(0, po, pw);
         chk($sformatf("slot0_frame%0d", f), 64'(po), 64'(f * 32'h100));
      end

      // Mid-frame reset, then wrap on {2,1} and hard sync of osc 2 by osc 0 of voice 2.
      for (int i = 0; i < 32; i++) inc_tbl[i] = 24'($urandom);
      inc_tbl[0]  = 24'h000100;
      inc_tbl[8]  = 24'hFFFFFF;
      inc_tbl[9]  = 24'hFFFFFF;
      inc_tbl[10] = 24'h000010;
      inc_tbl[11] = 24'h000020;
      sync_mask = 4'b0100;
      repeat (7) step();
      hit_reset();
      first_strobe(32'h100);
      for (int u = 1; u <= 256; u++) begin
         wait_slot(9, po, pw);
         if (u == 256) begin
            chk("slot9_upd256_phase", 64'(po), 64'hFFFF_FF00);
            chk("slot9_upd256_wrap", 64'(pw), 64'd0);
         end
      end
      for (int k = 0; k < 6; k++) begin
         wait_slot(wvec[k].slot, po, pw);
         chk({wvec[k].name, "_phase"}, 64'(po), 64'(wvec[k].exp_ph));
         chk({wvec[k].name, "_wrap"}, 64'(pw), 64'(wvec[k].exp_wrap));
      end

      // Key-on pulse on voice 5; neighbours keep accumulating.
      sync_mask = 4'b0000;
      for (int i = 0; i < 32; i++) inc_tbl[i] = 24'h000100 + 24'(i * 24'h10);
      hit_reset();
      repeat (3) wait_slot(23, po, pw);
      note_on = 1'b1; cur_key_adr = 3'd5;
      step();
      note_on = 1'b0; cur_key_adr = 3'd0;
      wait_slot(24, po, pw);
      chk("voice6_osc0_unaffected", 64'(po), 64'(3 * inc_tbl[24]));
      wait_slot(16, po, pw);
      chk("voice4_osc0_unaffected", 64'(po), 64'(4 * inc_tbl[16]));
      for (int o = 0; o < 4; o++) begin
         wait_slot(20 + o, po, pw);
         chk($sformatf("keyon_v5_osc%0d_phase", o), 64'(po), 64'(inc_tbl[20+o]));
         chk($sformatf("keyon_v5_osc%0d_wrap", o), 64'(pw), 64'd0);
      end

      // note_on held across three frames counts as one event.
      wait_slot(23, po, pw);
      note_on = 1'b1; cur_key_adr = 3'd5;
      for (int k = 1; k <= 4; k++) begin
         wait_slot(20, po, pw);
         chk($sformatf("held_keyon_v5_upd%0d", k), 64'(po), 64'(k * inc_tbl[20]));
         if (k == 3) note_on = 1'b0;
      end

      // Randomized traffic: increments, key-ons, voices and sync masks.
      rand_inc = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         note_on     = ($urandom % 6) == 0;
         cur_key_adr = 3'($urandom);
         sync_mask   = 4'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
